// File: rtl/nvram_upload_responder_pkg.sv
// Shared types and constants for the NVRAM/hiscore upload responder.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSING = 2'd1,
    READY   = 2'd2,
    FETCH   = 2'd3
  } state_t;

  localparam logic [7:0] UPLOAD_IDX_HISCORE = 8'd4;
  localparam logic [7:0] ZERO_FILL          = 8'h00;

  function automatic logic below_len(input logic [31:0] addr, input logic [31:0] len);
    return addr < len;
  endfunction

endpackage

// File: rtl/nvram_upload_responder_dirty_timer.sv
// Game-write dirty tracking with a quiet-time holdoff; emits the autosave request pulse.
module nvram_dirty_timer
  import nvram_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LENGTH  = 1024,
  parameter int HOLDOFF = 36000000
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          i_game_wr,
  input  logic [AW-1:0] i_game_addr,
  input  logic          i_autosave,
  input  logic          i_idle,
  input  logic          i_upload_end,
  output logic          o_upload_req
);
  localparam int             CW     = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(HOLDOFF - 1);

  logic          r_dirty;
  logic          r_req_sent;
  logic          r_wr_during_upload;
  logic [CW-1:0] r_cnt;
  logic          w_hit;
  logic          w_fire;

  assign w_hit        = i_game_wr && below_len(32'(i_game_addr), 32'(LENGTH));
  assign w_fire       = i_autosave && r_dirty && !r_req_sent && (r_cnt == '0) && i_idle;
  assign o_upload_req = w_fire;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_dirty            <= 1'b0;
      r_req_sent         <= 1'b0;
      r_wr_during_upload <= 1'b0;
      r_cnt              <= '0;
    end else begin
      if (w_hit)
        r_cnt <= RELOAD;
      else if (i_idle && (r_cnt != '0))
        r_cnt <= r_cnt - CW'(1);

      // Data just uploaded is clean unless the game touched it mid-transfer.
      if (i_upload_end) begin
        r_dirty            <= r_wr_during_upload | w_hit;
        r_wr_during_upload <= 1'b0;
      end else if (w_hit) begin
        if (i_idle)
          r_dirty <= 1'b1;
        else
          r_wr_during_upload <= 1'b1;
      end

      if (w_hit || i_upload_end)
        r_req_sent <= 1'b0;
      else if (w_fire)
        r_req_sent <= 1'b1;
    end
  end

endmodule

// File: rtl/nvram_upload_responder.sv
// HPS ioctl upload responder: serves a watched game RAM region byte by byte,
// pausing the game CPU for the transfer and requesting autosave after game writes.
module nvram_upload_responder
  import nvram_pkg::*;
#(
  parameter logic [7:0] INDEX   = UPLOAD_IDX_HISCORE,
  parameter int         AW      = 10,
  parameter int         LENGTH  = 1024,
  parameter int         RD_LAT  = 1,
  parameter int         HOLDOFF = 36000000
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  input  logic          autosave,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          game_wr,
  input  logic [AW-1:0] game_addr
);
  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_wait;
  logic          r_pause;
  logic          r_ram_rd;
  logic [AW-1:0] r_ram_addr;
  logic [7:0]    r_din;
  logic [1:0]    r_lat_cnt;

  logic          w_wait_nxt;
  logic          w_pause_nxt;
  logic          w_ram_rd_nxt;
  logic [AW-1:0] w_ram_addr_nxt;
  logic [7:0]    w_din_nxt;
  logic [1:0]    w_lat_cnt_nxt;

  logic          w_sel;
  logic          w_rd_ok;
  logic          w_in_range;
  logic          w_fetch_done;
  logic          w_upload_end;

  assign w_sel        = ioctl_upload && (ioctl_index == INDEX);
  // A strobe arriving while we still hold wait is a host protocol violation.
  assign w_rd_ok      = ioctl_rd && !r_wait;
  assign w_in_range   = below_len({7'd0, ioctl_addr}, 32'(LENGTH));
  assign w_fetch_done = (r_lat_cnt == 2'(RD_LAT));
  assign w_upload_end = !w_sel && (r_state != IDLE);

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_sel) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = PAUSING;
        PAUSING: if (paused) w_state_nxt = READY;
        READY:   if (w_rd_ok && w_in_range) w_state_nxt = FETCH;
        FETCH:   if (w_fetch_done) w_state_nxt = READY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; losing sel drops a pending fetch.
  always_comb begin
    w_wait_nxt     = 1'b0;
    w_pause_nxt    = 1'b0;
    w_ram_rd_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_din_nxt      = r_din;
    w_lat_cnt_nxt  = '0;
    if (w_sel) begin
      w_pause_nxt = 1'b1;
      case (r_state)
        IDLE:    w_wait_nxt = 1'b1;
        PAUSING: w_wait_nxt = !paused;
        READY: begin
          if (w_rd_ok) begin
            w_wait_nxt = 1'b1;
            if (w_in_range) begin
              w_ram_rd_nxt   = 1'b1;
              w_ram_addr_nxt = ioctl_addr[AW-1:0];
            end else begin
              w_din_nxt = ZERO_FILL;
            end
          end
        end
        FETCH: begin
          if (w_fetch_done) begin
            w_din_nxt = ram_q;
          end else begin
            w_wait_nxt    = 1'b1;
            w_lat_cnt_nxt = r_lat_cnt + 2'd1;
          end
        end
        default: w_wait_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_wait     <= 1'b0;
      r_pause    <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_din      <= '0;
      r_lat_cnt  <= '0;
    end else begin
      r_wait     <= w_wait_nxt;
      r_pause    <= w_pause_nxt;
      r_ram_rd   <= w_ram_rd_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_din      <= w_din_nxt;
      r_lat_cnt  <= w_lat_cnt_nxt;
    end
  end

  assign ioctl_wait = r_wait;
  assign pause_req  = r_pause;
  assign ram_rd     = r_ram_rd;
  assign ram_addr   = r_ram_addr;
  assign ioctl_din  = r_din;

  nvram_dirty_timer #(
    .AW      (AW),
    .LENGTH  (LENGTH),
    .HOLDOFF (HOLDOFF)
  ) u_dirty_timer (
    .clk_sys      (clk_sys),
    .RESET_n      (RESET_n),
    .i_game_wr    (game_wr),
    .i_game_addr  (game_addr),
    .i_autosave   (autosave),
    .i_idle       (r_state == IDLE),
    .i_upload_end (w_upload_end),
    .o_upload_req (ioctl_upload_req)
  );

endmodule

// File: tb/tb_nvram_upload_responder.sv
// Bench for nvram_upload_responder: two instances (RD_LAT 1 and 3) share stimulus.
module tb_nvram_upload_responder;
  import nvram_pkg::*;

  localparam int AW       = 11;
  localparam int LENGTH   = 1024;
  localparam int HOLDOFF  = 16;
  localparam int RD_LAT_A = 1;
  localparam int RD_LAT_B = 3;

  logic          clk_sys = 1'b0;
  logic          RESET_n = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_rd = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic          autosave = 1'b0;
  logic          paused = 1'b0;
  logic          game_wr = 1'b0;
  logic [AW-1:0] game_addr = '0;

  logic [7:0]    din_a, din_b, q_a, q_b;
  logic          wait_a, wait_b, req_a, req_b, pause_a, pause_b, rd_a, rd_b;
  logic [AW-1:0] raddr_a, raddr_b;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_responder #(.INDEX(8'd4), .AW(AW), .LENGTH(LENGTH), .RD_LAT(RD_LAT_A), .HOLDOFF(HOLDOFF)) u_dut_a (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wait_a),
    .ioctl_upload_req(req_a), .autosave(autosave), .pause_req(pause_a), .paused(paused),
    .ram_addr(raddr_a), .ram_rd(rd_a), .ram_q(q_a), .game_wr(game_wr), .game_addr(game_addr));

  nvram_upload_responder #(.INDEX(8'd4), .AW(AW), .LENGTH(LENGTH), .RD_LAT(RD_LAT_B), .HOLDOFF(HOLDOFF)) u_dut_b (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wait_b),
    .ioctl_upload_req(req_b), .autosave(autosave), .pause_req(pause_b), .paused(paused),
    .ram_addr(raddr_b), .ram_rd(rd_b), .ram_q(q_b), .game_wr(game_wr), .game_addr(game_addr));

  // RAM models: data only valid exactly RD_LAT cycles after ram_rd, junk otherwise.
  logic [7:0] mem [0:LENGTH-1];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b0, pipe_b1, pipe_b2;
  always @(posedge clk_sys) begin
    pipe_a  <= rd_a ? mem[raddr_a[9:0]] : 8'hEE;
    pipe_b0 <= rd_b ? mem[raddr_b[9:0]] : 8'hEE;
    pipe_b1 <= pipe_b0;
    pipe_b2 <= pipe_b1;
  end
  assign q_a = pipe_a;
  assign q_b = pipe_b2;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    repeat (3) tick();
    RESET_n = 1'b1;
    tick();
  endtask

  // Issues one read strobe and follows both responders until their waits fall.
  task automatic rd_xfer(input logic [24:0] addr,
                         output logic [7:0] da, output logic [7:0] db,
                         output int wa, output int wb, output int ra, output int rb,
                         output logic [AW-1:0] aa, output logic to);
    bit done_a, done_b;
    done_a = 0; done_b = 0;
    wa = 0; wb = 0; ra = 0; rb = 0; aa = '0; da = '0; db = '0;
    ioctl_rd = 1'b1;
    ioctl_addr = addr;
    tick();
    ioctl_rd = 1'b0;
    for (int k = 0; k < 16 && !(done_a && done_b); k++) begin
      if (!done_a) begin
        if (wait_a) wa++; else begin done_a = 1; da = din_a; end
      end
      if (!done_b) begin
        if (wait_b) wb++; else begin done_b = 1; db = din_b; end
      end
      if (rd_a) begin ra++; aa = raddr_a; end
      if (rd_b) rb++;
      if (!(done_a && done_b)) tick();
    end
    to = !(done_a && done_b);
  endtask

  int cnt_a, cnt_b, first_a, first_b;

  task automatic pulse_obs(input int k);
    #1;
    if (req_a) begin if (cnt_a == 0) first_a = k; cnt_a++; end
    if (req_b) begin if (cnt_b == 0) first_b = k; cnt_b++; end
  endtask

  task automatic clr_obs();
    cnt_a = 0; cnt_b = 0; first_a = -1; first_b = -1;
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    int          wa;
    int          wb;
    int          nrd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]    da, db;
    int            wa, wb, ra, rb;
    logic [AW-1:0] aa;
    logic          to;
    logic          any_hi;
    logic [24:0]   a;
    logic [7:0]    exp_d;
    int            last_wr;
    bit            m_dirty, m_sent, exp_p, wr;
    logic [AW-1:0] waddr;

    for (int i = 0; i < LENGTH; i++) mem[i] = 8'($urandom);
    mem[10'h012] = 8'hA5;
    mem[10'h000] = 8'h3C;
    mem[10'h3FF] = 8'h5A;

    vecs[0] = '{25'h0000012, 8'hA5, RD_LAT_A + 1, RD_LAT_B + 1, 1};
    vecs[1] = '{25'd1024,    8'h00, 1, 1, 0};
    vecs[2] = '{25'h0000000, 8'h3C, RD_LAT_A + 1, RD_LAT_B + 1, 1};
    vecs[3] = '{25'd1023,    8'h5A, RD_LAT_A + 1, RD_LAT_B + 1, 1};
    vecs[4] = '{25'h1FFFFFF, 8'h00, 1, 1, 0};

    // Reset state
    do_reset();
    chk("rst din", 32'(din_a), 32'h0);
    chk("rst wait", 32'(wait_a), 32'h0);
    chk("rst req", 32'(req_a), 32'h0);
    chk("rst pause", 32'(pause_a), 32'h0);
    chk("rst ram_rd", 32'(rd_a), 32'h0);
    chk("rst ram_addr", 32'(raddr_a), 32'h0);
    chk("rst wait_b", 32'(wait_b), 32'h0);
    chk("rst pause_b", 32'(pause_b), 32'h0);

    // Wrong index never engages
    ioctl_index = 8'd2;
    ioctl_upload = 1'b1;
    any_hi = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      any_hi = any_hi | pause_a | wait_a | pause_b | wait_b;
    end
    chk("wrong index pause/wait", 32'(any_hi), 32'h0);
    ioctl_upload = 1'b0;
    tick();

    // Upload handshake, paused arrives 5 cycles after sel
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("hs wait_a c%0d", k), 32'(wait_a), 32'(k < 6));
      chk($sformatf("hs wait_b c%0d", k), 32'(wait_b), 32'(k < 6));
      chk($sformatf("hs pause_a c%0d", k), 32'(pause_a), 32'h1);
      chk($sformatf("hs pause_b c%0d", k), 32'(pause_b), 32'h1);
      if (k == 5) paused = 1'b1;
    end

    // Table-driven reads
    for (int i = 0; i < 5; i++) begin
      rd_xfer(vecs[i].addr, da, db, wa, wb, ra, rb, aa, to);
      chk($sformatf("vec%0d timeout", i), 32'(to), 32'h0);
      chk($sformatf("vec%0d din_a", i), 32'(da), 32'(vecs[i].data));
      chk($sformatf("vec%0d din_b", i), 32'(db), 32'(vecs[i].data));
      chk($sformatf("vec%0d wait_a cycles", i), 32'(wa), 32'(vecs[i].wa));
      chk($sformatf("vec%0d wait_b cycles", i), 32'(wb), 32'(vecs[i].wb));
      chk($sformatf("vec%0d ram_rd_a count", i), 32'(ra), 32'(vecs[i].nrd));
      chk($sformatf("vec%0d ram_rd_b count", i), 32'(rb), 32'(vecs[i].nrd));
      if (vecs[i].nrd != 0)
        chk($sformatf("vec%0d ram_addr", i), 32'(aa), 32'(vecs[i].addr[AW-1:0]));
    end

    // Strobe during wait is ignored
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h12;
    tick();
    ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    for (int k = 0; k < 10 && (wait_a || wait_b); k++) tick();
    repeat (3) tick();
    chk("violation din_a", 32'(din_a), 32'hA5);
    chk("violation din_b", 32'(din_b), 32'hA5);
    chk("violation wait idle", 32'(wait_a | wait_b), 32'h0);

    // Randomized reads against the byte-level model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 25'(LENGTH + $urandom_range(0, 5000));
      else a = 25'($urandom_range(0, LENGTH - 1));
      exp_d = (a < 25'(LENGTH)) ? mem[a[9:0]] : ZERO_FILL;
      rd_xfer(a, da, db, wa, wb, ra, rb, aa, to);
      chk($sformatf("rnd%0d timeout", i), 32'(to), 32'h0);
      chk($sformatf("rnd%0d din_a @%0h", i, a), 32'(da), 32'(exp_d));
      chk($sformatf("rnd%0d din_b @%0h", i, a), 32'(db), 32'(exp_d));
      chk($sformatf("rnd%0d wait_a", i), 32'(wa), (a < 25'(LENGTH)) ? 32'(RD_LAT_A + 1) : 32'd1);
      chk($sformatf("rnd%0d wait_b", i), 32'(wb), (a < 25'(LENGTH)) ? 32'(RD_LAT_B + 1) : 32'd1);
    end

    // Abort mid-fetch on the RD_LAT=3 instance
    rd_xfer(25'd1024, da, db, wa, wb, ra, rb, aa, to);
    chk("pre-abort din_b", 32'(din_b), 32'h0);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h12;
    tick();
    ioctl_rd = 1'b0;
    chk("abort ram_rd_b", 32'(rd_b), 32'h1);
    tick();
    ioctl_upload = 1'b0;
    paused = 1'b0;
    tick();
    chk("abort wait_b", 32'(wait_b), 32'h0);
    chk("abort pause_b", 32'(pause_b), 32'h0);
    chk("abort pause_a", 32'(pause_a), 32'h0);
    chk("abort din_b", 32'(din_b), 32'h0);
    repeat (3) tick();
    chk("abort din_b later", 32'(din_b), 32'h0);
    chk("abort wait_b later", 32'(wait_b), 32'h0);

    // Autosave: writes at t=0 and t=10 give one pulse at t=26
    autosave = 1'b1;
    clr_obs();
    for (int k = 0; k <= 60; k++) begin
      game_wr = (k == 0 || k == 10);
      game_addr = 11'd5;
      pulse_obs(k);
      tick();
    end
    game_wr = 1'b0;
    chk("autosave count_a", 32'(cnt_a), 32'd1);
    chk("autosave time_a", 32'(first_a), 32'd26);
    chk("autosave count_b", 32'(cnt_b), 32'd1);
    chk("autosave time_b", 32'(first_b), 32'd26);

    // Write outside the region is ignored
    clr_obs();
    for (int k = 0; k <= 40; k++) begin
      game_wr = (k == 0);
      game_addr = 11'd2000;
      pulse_obs(k);
      tick();
    end
    game_wr = 1'b0;
    chk("oor write count_a", 32'(cnt_a), 32'd0);
    chk("oor write count_b", 32'(cnt_b), 32'd0);

    // Clean upload before holdoff expiry clears dirty
    clr_obs();
    for (int k = 0; k <= 50; k++) begin
      game_wr = (k == 0);
      game_addr = 11'd7;
      if (k == 3) ioctl_upload = 1'b1;
      if (k == 4) paused = 1'b1;
      if (k == 10) begin ioctl_upload = 1'b0; paused = 1'b0; end
      pulse_obs(k);
      tick();
    end
    game_wr = 1'b0;
    chk("clean upload count_a", 32'(cnt_a), 32'd0);
    chk("clean upload count_b", 32'(cnt_b), 32'd0);

    // Write during upload: idle from t=9, counter 15 there, zero at t=24
    clr_obs();
    for (int k = 0; k <= 50; k++) begin
      if (k == 0) ioctl_upload = 1'b1;
      if (k == 1) paused = 1'b1;
      game_wr = (k == 4);
      game_addr = 11'd9;
      if (k == 8) begin ioctl_upload = 1'b0; paused = 1'b0; end
      pulse_obs(k);
      tick();
    end
    game_wr = 1'b0;
    chk("upload write count_a", 32'(cnt_a), 32'd1);
    chk("upload write time_a", 32'(first_a), 32'd24);
    chk("upload write count_b", 32'(cnt_b), 32'd1);

    // autosave=0 suppresses but keeps tracking
    clr_obs();
    for (int k = 0; k <= 40; k++) begin
      autosave = (k >= 30);
      game_wr = (k == 0);
      game_addr = 11'd3;
      pulse_obs(k);
      tick();
    end
    game_wr = 1'b0;
    chk("suppressed count_a", 32'(cnt_a), 32'd1);
    chk("suppressed time_a", 32'(first_a), 32'd30);
    chk("suppressed time_b", 32'(first_b), 32'd30);

    // Randomized writes against the time-based request model
    do_reset();
    last_wr = -1000;
    m_dirty = 0;
    m_sent = 0;
    autosave = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) autosave = ~autosave;
      wr = ($urandom_range(0, 11) == 0);
      waddr = AW'($urandom_range(0, 2047));
      game_wr = wr;
      game_addr = waddr;
      #1;
      exp_p = autosave && m_dirty && !m_sent && (k - last_wr >= HOLDOFF);
      chk($sformatf("rnd req_a k%0d", k), 32'(req_a), 32'(exp_p));
      chk($sformatf("rnd req_b k%0d", k), 32'(req_b), 32'(exp_p));
      if (exp_p) m_sent = 1;
      if (wr && waddr < AW'(LENGTH)) begin
        m_dirty = 1;
        m_sent = 0;
        last_wr = k;
      end
      tick();
    end
    game_wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
